// File: rtl/mul_seq_8bit.sv
// -----------------------------------------------------------------------------
// mul_seq_8bit
//
// Sequential 8x8 unsigned shift-and-add multiplier. One 8-bit ripple adder is
// reused over eight RUN steps to build a 16-bit product. Handshake toward the
// ALU control is start / busy / done.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous active-high reset (priority over start)
//   start    in   1   multiply request, only looked at in IDLE
//   a        in   8   multiplicand, captured when start is accepted
//   b        in   8   multiplier, captured when start is accepted
//   product  out  16  last completed result, held until the next completion
//   busy     out  1   high while RUN
//   done     out  1   one-cycle pulse while in DONE
//
// Build option:
//   MUL_EARLY_TERM_EN  when defined, a zero operand at acceptance skips RUN and
//                      goes straight to DONE with a zero product.
// -----------------------------------------------------------------------------

// 8-bit ripple-carry adder, carry-in fixed at zero.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       c_out
);
    logic [8:0] carry;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = carry[8];
endmodule

module mul_seq_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  acc_q,   acc_d;
    logic [7:0]  q_q,     q_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [15:0] product_q, product_d;

    logic [7:0]  add_sum;
    logic        add_c;
    logic [8:0]  partial;    // {c,s}: adder result or pass-through of acc
    logic [15:0] step_val;   // {acc,q} after one shift step

    adder_8bit u_adder (
        .a     (acc_q),
        .b     (mcand_q),
        .sum   (add_sum),
        .c_out (add_c)
    );

    always_comb begin
        // Only add the multiplicand when the current multiplier bit is set.
        // The carry is kept and shifted in as the new MSB of acc.
        partial  = q_q[0] ? {add_c, add_sum} : {1'b0, acc_q};
        step_val = {partial, q_q[7:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    q_d     = b;
                    acc_d   = 8'h00;
                    cnt_d   = 3'd0;
`ifdef MUL_EARLY_TERM_EN
                    if ((a == 8'h00) || (b == 8'h00)) begin
                        product_d = 16'h0000;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                    end
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN: begin
                acc_d = step_val[15:8];
                q_d   = step_val[7:0];
                // Wraps 7 -> 0 on the last step; IDLE reloads it anyway.
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    product_d = step_val;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately ignored here; it is not queued.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= 8'h00;
            acc_q     <= 8'h00;
            q_q       <= 8'h00;
            cnt_q     <= 3'd0;
            product_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Decoded from registered state only: no path from start to busy/done.
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
endmodule
